// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and downstream memory ports of mem_port_arbiter.
// slave is the arbiter side; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MW = DATA_W / 8;

  logic [ADDR_W-1:0] imem_addr;
  logic [MW-1:0]     imem_rmask;
  logic              imem_flush;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_resp;

  logic [ADDR_W-1:0] dmem_addr;
  logic [MW-1:0]     dmem_rmask;
  logic [MW-1:0]     dmem_wmask;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_resp;

  logic [ADDR_W-1:0] mem_addr;
  logic [MW-1:0]     mem_rmask;
  logic [MW-1:0]     mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  imem_addr, imem_rmask, imem_flush,
    output imem_rdata, imem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask,
    input  dmem_wdata,
    output dmem_rdata, dmem_resp,
    output mem_addr, mem_rmask, mem_wmask,
    output mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output imem_addr, imem_rmask, imem_flush,
    input  imem_rdata, imem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask,
    output dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  mem_addr, mem_rmask, mem_wmask,
    input  mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters.
// Data wins; one transaction outstanding; fetches can be squashed.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int MW = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MW-1:0]     rmask;
  } ireq_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MW-1:0]     rmask;
    logic [MW-1:0]     wmask;
    logic [DATA_W-1:0] wdata;
  } dreq_t;

  state_t state, state_n;
  logic   i_pend, i_pend_n;
  logic   d_pend, d_pend_n;
  logic   drop, drop_n;
  ireq_t  i_q;
  dreq_t  d_q;
  logic   [ADDR_W-1:0] addr_q;
  logic   [DATA_W-1:0] wdata_q;
  logic   i_new, d_new;
  logic   issue_i, issue_d;

  assign i_new = |bus.imem_rmask;
  assign d_new = (|bus.dmem_rmask) || (|bus.dmem_wmask);

  assign bus.imem_rdata = bus.mem_rdata;
  assign bus.dmem_rdata = bus.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      i_pend <= 1'b0;
      d_pend <= 1'b0;
      drop   <= 1'b0;
    end else begin
      state  <= state_n;
      i_pend <= i_pend_n;
      d_pend <= d_pend_n;
      drop   <= drop_n;
    end
  end

  // Request capture plus the held address/data seen between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q     <= '0;
      d_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (i_new) begin
        i_q <= '{bus.imem_addr, bus.imem_rmask};
      end
      if (d_new) begin
        d_q <= '{bus.dmem_addr, bus.dmem_rmask,
                 bus.dmem_wmask, bus.dmem_wdata};
      end
      if (issue_d) begin
        addr_q  <= d_q.addr;
        wdata_q <= d_q.wdata;
      end else if (issue_i) begin
        addr_q  <= i_q.addr;
      end
    end
  end

  always_comb begin
    state_n       = state;
    i_pend_n      = i_pend;
    d_pend_n      = d_pend;
    drop_n        = drop;
    issue_i       = 1'b0;
    issue_d       = 1'b0;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_rmask = '0;
    bus.mem_wmask = '0;
    bus.imem_resp = 1'b0;
    bus.dmem_resp = 1'b0;

    unique case (state)
      IDLE: begin
        if (d_pend) begin
          issue_d       = 1'b1;
          d_pend_n      = 1'b0;
          state_n       = BUSY_D;
          bus.mem_addr  = d_q.addr;
          bus.mem_wdata = d_q.wdata;
          bus.mem_rmask = d_q.rmask;
          bus.mem_wmask = d_q.wmask;
        end else if (i_pend) begin
          issue_i       = 1'b1;
          i_pend_n      = 1'b0;
          state_n       = BUSY_I;
          // A flush landing on the issue cycle kills this fetch.
          drop_n        = bus.imem_flush;
          bus.mem_addr  = i_q.addr;
          bus.mem_rmask = i_q.rmask;
        end
      end
      BUSY_I: begin
        if (bus.mem_resp) begin
          bus.imem_resp = !drop && !bus.imem_flush;
          drop_n        = 1'b0;
          state_n       = IDLE;
        end else if (bus.imem_flush) begin
          drop_n        = 1'b1;
        end
      end
      BUSY_D: begin
        if (bus.mem_resp) begin
          bus.dmem_resp = 1'b1;
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (bus.imem_flush) i_pend_n = 1'b0;
    if (i_new)          i_pend_n = 1'b1;
    if (d_new)          d_pend_n = 1'b1;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table then
// randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          rst;
    logic [3:0]  ir;
    logic [31:0] ia;
    bit          fl;
    logic [3:0]  dr;
    logic [3:0]  dw;
    logic [31:0] da;
    logic [31:0] dwd;
    bit          mr;
    logic [31:0] mrd;
    logic [3:0]  emr;
    logic [3:0]  emw;
    logic [31:0] ema;
    logic [31:0] ewd;
    bit          eir;
    bit          edr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    bit rst, logic [3:0] ir, logic [31:0] ia, bit fl,
    logic [3:0] dr, logic [3:0] dw, logic [31:0] da,
    logic [31:0] dwd, bit mr, logic [31:0] mrd,
    logic [3:0] emr, logic [3:0] emw, logic [31:0] ema,
    logic [31:0] ewd, bit eir, bit edr);
    vec_t v;
    v = '{rst, ir, ia, fl, dr, dw, da, dwd, mr, mrd,
          emr, emw, ema, ewd, eir, edr};
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Requester protocol watch: one live request per requester.
  bit i_out, d_out;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_out <= 1'b0;
      d_out <= 1'b0;
    end else begin
      assert (!((|bus.imem_rmask) && i_out && !bus.imem_flush))
        else $error("illegal second imem request");
      assert (!(((|bus.dmem_rmask) || (|bus.dmem_wmask)) && d_out))
        else $error("illegal second dmem request");
      if (|bus.imem_rmask) i_out <= 1'b1;
      else if (bus.imem_resp || bus.imem_flush) i_out <= 1'b0;
      if ((|bus.dmem_rmask) || (|bus.dmem_wmask)) d_out <= 1'b1;
      else if (bus.dmem_resp) d_out <= 1'b0;
    end
  end

  task automatic drive(bit fl, logic [3:0] ir, logic [31:0] ia,
                       logic [3:0] dr, logic [3:0] dw,
                       logic [31:0] da, logic [31:0] dwd,
                       bit mr, logic [31:0] mrd);
    bus.imem_flush = fl;
    bus.imem_rmask = ir;
    bus.imem_addr  = ia;
    bus.dmem_rmask = dr;
    bus.dmem_wmask = dw;
    bus.dmem_addr  = da;
    bus.dmem_wdata = dwd;
    bus.mem_resp   = mr;
    bus.mem_rdata  = mrd;
  endtask

  task automatic chk_out(string p, logic [3:0] emr,
                         logic [3:0] emw, logic [31:0] ema,
                         logic [31:0] ewd, bit eir, bit edr,
                         logic [31:0] mrd);
    chk({p, " mem_rmask"}, 32'(bus.mem_rmask), 32'(emr));
    chk({p, " mem_wmask"}, 32'(bus.mem_wmask), 32'(emw));
    chk({p, " mem_addr"}, bus.mem_addr, ema);
    chk({p, " mem_wdata"}, bus.mem_wdata, ewd);
    chk({p, " imem_resp"}, 32'(bus.imem_resp), 32'(eir));
    chk({p, " dmem_resp"}, 32'(bus.dmem_resp), 32'(edr));
    if (eir) chk({p, " imem_rdata"}, bus.imem_rdata, mrd);
    if (edr) chk({p, " dmem_rdata"}, bus.dmem_rdata, mrd);
  endtask

  task automatic run_vec(vec_t v, int idx);
    @(negedge clk);
    rst_n = !v.rst;
    drive(v.fl, v.ir, v.ia, v.dr, v.dw, v.da, v.dwd, v.mr, v.mrd);
    #1;
    chk_out($sformatf("v%0d", idx), v.emr, v.emw, v.ema,
            v.ewd, v.eir, v.edr, v.mrd);
  endtask

  task automatic rand_phase(int cycles);
    bit ip, dp, i_live, d_live, dropped;
    logic [31:0] m_ia, m_da, m_dwd, last_a, last_wd;
    logic [3:0]  m_irm, m_drm, m_dwm;
    int infl, cnt;
    bit fl, mr, iq, dq, resp_now, e_ir, e_dr;
    logic [3:0]  ir, dr, dw, e_mr, e_mw;
    logic [31:0] ia, da, dwd, mrd, e_ma, e_wd;
    int issue;

    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ip = 0; dp = 0; i_live = 0; d_live = 0; dropped = 0;
    m_ia = 0; m_da = 0; m_dwd = 0; m_irm = 0; m_drm = 0;
    m_dwm = 0; last_a = 0; last_wd = 0; infl = 0; cnt = 0;

    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      fl = ($urandom_range(0, 12) == 0);
      iq = (!i_live || fl) && ($urandom_range(0, 2) == 0);
      dq = !d_live && ($urandom_range(0, 2) == 0);
      ir = iq ? 4'($urandom_range(1, 15)) : 4'h0;
      ia = $urandom & 32'hFFFF_FFFC;
      dr = 0;
      dw = 0;
      if (dq) begin
        if ($urandom_range(0, 1) == 1) dw = 4'($urandom_range(1, 15));
        else dr = 4'($urandom_range(1, 15));
      end
      da  = $urandom;
      dwd = $urandom;
      mrd = $urandom;
      if (infl != 0) begin
        cnt--;
        mr = (cnt == 0);
      end else begin
        mr = ($urandom_range(0, 7) == 0);
      end
      drive(fl, ir, ia, dr, dw, da, dwd, mr, mrd);

      // Expected port behaviour this cycle.
      issue = 0;
      if (infl == 0) issue = dp ? 2 : (ip ? 1 : 0);
      e_mr = (issue == 2) ? m_drm : (issue == 1) ? m_irm : 4'h0;
      e_mw = (issue == 2) ? m_dwm : 4'h0;
      e_ma = (issue == 2) ? m_da : (issue == 1) ? m_ia : last_a;
      e_wd = (issue == 2) ? m_dwd : last_wd;
      resp_now = mr && (infl != 0);
      e_ir = resp_now && infl == 1 && !dropped && !fl;
      e_dr = resp_now && infl == 2;
      #1;
      chk_out($sformatf("r%0d", c), e_mr, e_mw, e_ma, e_wd,
              e_ir, e_dr, mrd);

      // Advance the model across the clock edge.
      if (issue != 0) begin
        infl = issue;
        cnt = $urandom_range(1, 4);
        last_a = e_ma;
        last_wd = e_wd;
        if (issue == 2) dp = 0;
        else begin
          ip = 0;
          dropped = fl;
        end
      end else if (resp_now) begin
        infl = 0;
        dropped = 0;
      end else if (fl && infl == 1) begin
        dropped = 1;
      end
      if (fl) ip = 0;
      if (e_ir || fl) i_live = 0;
      if (e_dr) d_live = 0;
      if (iq) begin
        ip = 1; i_live = 1; m_ia = ia; m_irm = ir;
      end
      if (dq) begin
        dp = 1; d_live = 1; m_da = da;
        m_drm = dr; m_dwm = dw; m_dwd = dwd;
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // rst ir ia fl dr dw da dwd mr mrd | emr emw ema ewd eir edr
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 0, 0, 0, 0, 0, 0));
    // single fetch
    vecs.push_back(mk(0, 4'hF, 32'h6000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 32'h6000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h6000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h6000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13, 0, 0, 32'h6000_0000, 0, 1, 0));
    // simultaneous: dmem first
    vecs.push_back(mk(0, 4'hF, 32'h6000_0004, 0, 4'h1, 0, 32'h7000_0000, 0, 0, 0, 0, 0, 32'h6000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h1, 0, 32'h7000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAABB_CCDD, 0, 0, 32'h7000_0000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 32'h6000_0004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 0, 0, 32'h6000_0004, 0, 1, 0));
    // store
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'h3, 32'h7000_0002, 32'hBEEF, 0, 0, 0, 0, 32'h6000_0004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h3, 32'h7000_0002, 32'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A, 0, 0, 32'h7000_0002, 32'hBEEF, 0, 1));
    // flush in flight with redirect
    vecs.push_back(mk(0, 4'hF, 32'h6000_0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7000_0002, 32'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 32'h6000_0010, 32'hBEEF, 0, 0));
    vecs.push_back(mk(0, 4'hF, 32'h6000_0100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h6000_0010, 32'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD, 0, 0, 32'h6000_0010, 32'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 32'h6000_0100, 32'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 0, 0, 32'h6000_0100, 32'hBEEF, 1, 0));
    // flush before issue
    vecs.push_back(mk(0, 4'hF, 32'h6000_0200, 0, 4'hF, 0, 32'h7000_0010, 0, 0, 0, 0, 0, 32'h6000_0100, 32'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 32'h7000_0010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7000_0010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 0, 32'h7000_0010, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7000_0010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7000_0010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h1, 0, 32'h7000_0020, 0, 0, 0, 0, 0, 32'h7000_0010, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h1, 0, 32'h7000_0020, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 32'h7000_0020, 0, 0, 1));
    // reset during BUSY_D, late mem_resp ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'hF, 32'h7000_0030, 32'hCAFE_F00D, 0, 0, 0, 0, 32'h7000_0020, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 32'h7000_0030, 32'hCAFE_F00D, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h42, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h43, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 32'h6000_0300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 32'h6000_0300, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0, 32'h6000_0300, 0, 1, 0));

    foreach (vecs[i]) run_vec(vecs[i], i);

    rand_phase(4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
